note_envelope_synth: RTL
========================

Name: note_envelope_synth

Overview:
- Downstream consumer of the beat-indexed tone stage: takes the per-beat tone frequency (Hz, 0 = rest) and the beat-rate square wave, and drives the speaker pmod line.
- Replaces a bare fixed-50%-duty tone PWM. Each note gets a short silent articulation gap at its start, then a stepped duty-cycle attack ramp (soft onset), then sustain.
- Glitch-free: a new period or duty takes effect only at a waveform period boundary.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz; numerator for period computation.
- GAP_CYCLES, 1_000_000, silent clocks at the start of each note (10 ms).
- ENV_STEP_CYCLES, 100_000, clocks between attack duty increments.
- DUTY_MIN, 10'd128, attack start duty (of 1024).
- DUTY_MAX, 10'd512, sustain duty (of 1024).
- DUTY_STEP, 10'd64, attack duty increment.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- beat  input  1  beat-rate square wave (same clk domain); rising edge = new beat
- tone  input  32  note frequency in Hz; 0 = rest
- enable  input  1  1 = play; 0 = force silence
- audio_out  output  1  square-wave output to pmod
- note_active  output  1  high in ATTACK or SUSTAIN
- env_state  output  2  0 IDLE, 1 GAP, 2 ATTACK, 3 SUSTAIN

Behaviour:
- Reset: one clock with reset high sets state IDLE, audio_out 0, note_active 0, env_state 0, all counters 0, duty DUTY_MIN, latched tone 0, beat_q 0. Reset overrides all other inputs, including mid-note.
- Beat edge: beat_q registers beat. beat_rise = beat & ~beat_q. The tone input is sampled only on beat_rise; changes to tone between beats are ignored.
- Tone validity: a latched tone is valid when tone != 0 and tone <= CLK_FREQ/2. Otherwise it is a rest. No divide by zero is ever performed.
- Period: period = CLK_FREQ / tone, integer floor, 32-bit, computed from the latched tone. The result is available before ATTACK begins (GAP_CYCLES >= 2 is guaranteed).
- Duty: hi_cnt = (period * duty) >> 10, using a 42-bit product.
- FSM transitions. Priority: reset > enable low > beat_rise > internal.
  - Any state, enable=0: go to IDLE next clock.
  - Any state, beat_rise with enable=1 and valid tone: go to GAP, load the gap counter, set duty = DUTY_MIN. This restarts a note even mid-ATTACK or mid-SUSTAIN, so repeated notes re-articulate.
  - Any state, beat_rise with enable=1 and a rest tone: go to IDLE.
  - GAP: lasts exactly GAP_CYCLES clocks, then ATTACK with wave counter 0 and step counter 0.
  - ATTACK: every ENV_STEP_CYCLES clocks, duty = min(duty + DUTY_STEP, DUTY_MAX). When duty reaches DUTY_MAX, go to SUSTAIN.
  - SUSTAIN: hold duty until the next beat_rise or enable low.
- Waveform (ATTACK and SUSTAIN only):
  - Wave counter counts 0..period-1 and wraps.
  - audio_out is registered: audio_out = (cnt < hi_cnt_active).
  - hi_cnt_active reloads from the current duty only when cnt wraps to 0, or on ATTACK entry.
- In IDLE and GAP, audio_out = 0 and the wave counter is held at 0.
- Latency: beat_rise sampled at clock T gives GAP at T+1 and ATTACK at T+1+GAP_CYCLES. The first audio_out high is at T+2+GAP_CYCLES, provided hi_cnt > 0.
- hi_cnt = 0 gives a silent output. This is legal and is not an error.
- note_active and env_state are registered and decode the current state.

Test Plan:
Bench parameters: CLK_FREQ=1000, GAP_CYCLES=4, ENV_STEP_CYCLES=20, DUTY_MIN=256, DUTY_MAX=512, DUTY_STEP=128.
- Reset mid-SUSTAIN, tone=100 -> next clock env_state=0, audio_out=0, note_active=0. It stays silent with no beat edge after reset drops.
- tone=100, beat rises at T -> env_state=1 at T+1..T+4; ATTACK at T+5; audio_out high at T+6.
  - Period 10; hi_cnt 2 at duty 256, then 3 at duty 384.
  - SUSTAIN is reached after 2 steps; SUSTAIN pattern is 5 high / 5 low.
- tone=100 and the same tone on the next beat while in SUSTAIN -> audio_out=0 for 4 clocks (GAP), then the attack ramp restarts at duty 256.
- tone=0 on a beat, and separately tone=600 (above CLK_FREQ/2) on a beat -> IDLE, audio_out constantly 0.
  - Next beat with tone=250 -> period 4; duty 256 gives 1 high / 3 low.
- Duty step lands mid-period -> the high width changes only from the next period start. No period may contain a truncated or extended high pulse.
- enable dropped mid-ATTACK -> IDLE next clock. With enable high again, no sound until the next beat_rise.

Source files
------------

// File: rtl/note_envelope_synth.sv
// Note-articulating tone generator: silent gap, stepped-duty attack, then sustain.
// Period and duty changes are applied only at waveform period boundaries.
module note_envelope_synth #(
  parameter int unsigned CLK_FREQ        = 100_000_000,
  parameter int unsigned GAP_CYCLES      = 1_000_000,
  parameter int unsigned ENV_STEP_CYCLES = 100_000,
  parameter logic [9:0]  DUTY_MIN        = 10'd128,
  parameter logic [9:0]  DUTY_MAX        = 10'd512,
  parameter logic [9:0]  DUTY_STEP       = 10'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        beat,
  input  logic [31:0] tone,
  input  logic        enable,
  output logic        audio_out,
  output logic        note_active,
  output logic [1:0]  env_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GAP     = 2'd1,
    ATTACK  = 2'd2,
    SUSTAIN = 2'd3
  } state_t;

  localparam logic [31:0] CLK_FREQ_W = 32'(CLK_FREQ);
  localparam logic [31:0] HALF_FREQ  = CLK_FREQ_W >> 1;
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] STEP_LAST  = 32'(ENV_STEP_CYCLES - 1);

  state_t      state_q, state_d;
  logic        beat_q;
  logic [31:0] tone_q, tone_d;
  logic [31:0] period_q, period_d;
  logic [9:0]  duty_q, duty_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [31:0] wave_cnt_q, wave_cnt_d;
  logic [31:0] hi_act_q, hi_act_d;
  logic        audio_q, audio_d;
  logic        note_active_q, note_active_d;
  logic [1:0]  env_state_q, env_state_d;

  logic        beat_rise;
  logic        tone_ok;
  logic [31:0] divisor;
  logic [41:0] hi_prod;
  logic [31:0] hi_cnt;
  logic [10:0] duty_sum;
  logic [9:0]  duty_inc;
  logic        step_done;
  logic        wave_wrap;

  assign beat_rise = beat & ~beat_q;
  assign tone_ok   = (tone != '0) && (tone <= HALF_FREQ);

  // Period is recomputed every clock from the latched tone; the gap (>= 2 clocks)
  // guarantees it has settled before the first ATTACK clock uses it.
  assign divisor   = (tone_q == '0) ? 32'd1 : tone_q;
  assign period_d  = CLK_FREQ_W / divisor;

  assign hi_prod   = {10'd0, period_q} * {32'd0, duty_q};
  assign hi_cnt    = 32'(hi_prod >> 10);

  assign duty_sum  = {1'b0, duty_q} + {1'b0, DUTY_STEP};
  assign duty_inc  = (duty_sum >= {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_sum[9:0];
  assign step_done = (step_cnt_q == STEP_LAST);
  assign wave_wrap = (wave_cnt_q >= period_q - 32'd1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (beat_rise) begin
      state_d = tone_ok ? GAP : IDLE;
    end else begin
      case (state_q)
        GAP:     if (gap_cnt_q == '0) state_d = ATTACK;
        ATTACK:  if (step_done && (duty_inc == DUTY_MAX)) state_d = SUSTAIN;
        default: state_d = state_q;
      endcase
    end
  end

  // Output / datapath next-state logic
  always_comb begin
    tone_d        = tone_q;
    duty_d        = duty_q;
    gap_cnt_d     = gap_cnt_q;
    step_cnt_d    = step_cnt_q;
    wave_cnt_d    = '0;
    hi_act_d      = hi_act_q;
    audio_d       = 1'b0;
    note_active_d = (state_d == ATTACK) || (state_d == SUSTAIN);
    env_state_d   = state_d;

    if (beat_rise) begin
      tone_d = tone;
    end

    if (enable && beat_rise) begin
      gap_cnt_d  = GAP_LAST;
      duty_d     = DUTY_MIN;
      step_cnt_d = '0;
    end else if (enable) begin
      case (state_q)
        GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - 32'd1;
          end else begin
            step_cnt_d = '0;
            hi_act_d   = hi_cnt;
          end
        end
        ATTACK, SUSTAIN: begin
          audio_d = (wave_cnt_q < hi_act_q);
          if (wave_wrap) begin
            wave_cnt_d = '0;
            hi_act_d   = hi_cnt;
          end else begin
            wave_cnt_d = wave_cnt_q + 32'd1;
          end
          if (state_q == ATTACK) begin
            if (step_done) begin
              step_cnt_d = '0;
              duty_d     = duty_inc;
            end else begin
              step_cnt_d = step_cnt_q + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q        <= 1'b0;
      tone_q        <= '0;
      period_q      <= '0;
      duty_q        <= DUTY_MIN;
      gap_cnt_q     <= '0;
      step_cnt_q    <= '0;
      wave_cnt_q    <= '0;
      hi_act_q      <= '0;
      audio_q       <= 1'b0;
      note_active_q <= 1'b0;
      env_state_q   <= '0;
    end else begin
      beat_q        <= beat;
      tone_q        <= tone_d;
      period_q      <= period_d;
      duty_q        <= duty_d;
      gap_cnt_q     <= gap_cnt_d;
      step_cnt_q    <= step_cnt_d;
      wave_cnt_q    <= wave_cnt_d;
      hi_act_q      <= hi_act_d;
      audio_q       <= audio_d;
      note_active_q <= note_active_d;
      env_state_q   <= env_state_d;
    end
  end

  assign audio_out   = audio_q;
  assign note_active = note_active_q;
  assign env_state   = env_state_q;

endmodule
